// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core and its SQI memory models.
package idli_pkg;

  typedef logic [3:0] slice_t;

  typedef enum logic [2:0] {
    SQI_IDLE,
    SQI_CMD,
    SQI_ADDR,
    SQI_DUMMY,
    SQI_RD_DATA,
    SQI_WR_DATA,
    SQI_IGNORE
  } sqi_state_t;

  typedef enum logic [7:0] {
    SQI_CMD_WRITE = 8'h02,
    SQI_CMD_READ  = 8'h03
  } sqi_cmd_t;

  localparam int SQI_ADDR_NIBBLES  = 6;
  localparam int SQI_DUMMY_NIBBLES = 2;

endpackage

// File: rtl/idli_sqi_mem_m_ram.sv
// Byte-wide storage for the SQI memory model: one registered read port, one write port.
module idli_sqi_ram_m #(
  parameter int ADDR_W = 16
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [2**ADDR_W];
  logic [7:0] r_rdata;

  // Contents are deliberately left unreset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial-SRAM responder: decodes READ/WRITE on sck/cs/sio and returns data
// nibble-serially, with a backdoor byte-write port for preloading images.
module idli_sqi_mem_m
  import idli_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              i_sqi_gck,
  input  logic              i_sqi_rst_n,
  input  logic              i_sqi_sck,
  input  logic              i_sqi_cs,
  input  slice_t            i_sqi_sio,
  output slice_t            o_sqi_sio,
  output logic              o_sqi_sio_oe,
  input  logic              i_sqi_bd_we,
  input  logic [ADDR_W-1:0] i_sqi_bd_addr,
  input  logic [7:0]        i_sqi_bd_data
);

  localparam logic [2:0]        ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
  localparam logic [2:0]        DUMMY_LAST = 3'(SQI_DUMMY_NIBBLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  sqi_state_t        r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  slice_t            r_cmd_hi;
  logic              r_is_rd;
  slice_t            r_lo;
  slice_t            r_hold;
  slice_t            r_sio;
  logic              r_oe;

  logic              w_beat;
  logic [7:0]        w_cmd;
  logic              w_wr_en;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [7:0]        w_ram_wdata;
  logic [7:0]        w_rd_data;

  assign w_beat  = !i_sqi_cs && i_sqi_sck;
  assign w_cmd   = {r_cmd_hi, i_sqi_sio};
  assign w_wr_en = w_beat && (r_state == SQI_WR_DATA) && r_cnt[0];

  // Backdoor wins when both sources write on the same edge.
  assign w_ram_we    = i_sqi_bd_we || w_wr_en;
  assign w_ram_waddr = i_sqi_bd_we ? i_sqi_bd_addr : r_addr;
  assign w_ram_wdata = i_sqi_bd_we ? i_sqi_bd_data : {r_hold, i_sqi_sio};

  idli_sqi_ram_m #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (i_sqi_gck),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_rd_data)
  );

  // The RAM re-reads mem[r_addr] every gck, so by the last dummy beat (and by each
  // high-nibble beat, since r_addr advances one beat early) the byte is ready.
  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_state  <= SQI_IDLE;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_cmd_hi <= '0;
      r_is_rd  <= 1'b0;
      r_lo     <= '0;
      r_hold   <= '0;
      r_sio    <= '0;
      r_oe     <= 1'b0;
    end else if (i_sqi_cs) begin
      r_state <= SQI_IDLE;
      r_cnt   <= '0;
      r_oe    <= 1'b0;
    end else if (w_beat) begin
      case (r_state)
        SQI_IDLE: begin
          r_cmd_hi <= i_sqi_sio;
          r_state  <= SQI_CMD;
        end
        SQI_CMD: begin
          r_cnt <= '0;
          if (w_cmd == SQI_CMD_READ) begin
            r_is_rd <= 1'b1;
            r_state <= SQI_ADDR;
          end else if (w_cmd == SQI_CMD_WRITE) begin
            r_is_rd <= 1'b0;
            r_state <= SQI_ADDR;
          end else begin
            r_state <= SQI_IGNORE;
          end
        end
        SQI_ADDR: begin
          // Upper address nibbles shift off the top, truncating to ADDR_W.
          r_addr <= {r_addr[ADDR_W-5:0], i_sqi_sio};
          if (r_cnt == ADDR_LAST) begin
            r_cnt   <= '0;
            r_state <= r_is_rd ? SQI_DUMMY : SQI_WR_DATA;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        SQI_DUMMY: begin
          if (r_cnt == DUMMY_LAST) begin
            r_sio   <= w_rd_data[7:4];
            r_lo    <= w_rd_data[3:0];
            r_addr  <= r_addr + ADDR_ONE;
            r_oe    <= 1'b1;
            r_cnt   <= 3'd1;
            r_state <= SQI_RD_DATA;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        SQI_RD_DATA: begin
          if (r_cnt[0]) begin
            r_sio <= r_lo;
            r_cnt <= '0;
          end else begin
            r_sio  <= w_rd_data[7:4];
            r_lo   <= w_rd_data[3:0];
            r_addr <= r_addr + ADDR_ONE;
            r_cnt  <= 3'd1;
          end
        end
        SQI_WR_DATA: begin
          if (r_cnt[0]) begin
            r_addr <= r_addr + ADDR_ONE;
            r_cnt  <= '0;
          end else begin
            r_hold <= i_sqi_sio;
            r_cnt  <= 3'd1;
          end
        end
        SQI_IGNORE: begin
          r_state <= SQI_IGNORE;
        end
        default: begin
          r_state <= SQI_IDLE;
        end
      endcase
    end
  end

  assign o_sqi_sio    = r_sio;
  assign o_sqi_sio_oe = r_oe;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: SQI write/read transactions, backdoor preload,
// wrap, partial bytes, unknown commands, aborts, reset and sck gaps.
module tb_idli_sqi_mem_m;
  import idli_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sck;
  logic        cs;
  slice_t      sio_in;
  slice_t      sio_out;
  logic        sio_oe;
  logic        bd_we;
  logic [15:0] bd_addr;
  logic [7:0]  bd_data;

  int n_checks;
  int n_errors;

  idli_sqi_mem_m #(.ADDR_W(16)) dut (
    .i_sqi_gck     (clk),
    .i_sqi_rst_n   (rst_n),
    .i_sqi_sck     (sck),
    .i_sqi_cs      (cs),
    .i_sqi_sio     (sio_in),
    .o_sqi_sio     (sio_out),
    .o_sqi_sio_oe  (sio_oe),
    .i_sqi_bd_we   (bd_we),
    .i_sqi_bd_addr (bd_addr),
    .i_sqi_bd_data (bd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic sqi_beat(input logic [3:0] nib, input int gap);
    cs = 1'b0; sck = 1'b1; sio_in = nib;
    @(posedge clk); #1;
    sck = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic cs_high();
    cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
    @(posedge clk); #1;
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr, input int gap);
    sqi_beat(cmd[7:4], gap);
    sqi_beat(cmd[3:0], gap);
    for (int k = 0; k < 6; k++) sqi_beat(addr[23-4*k -: 4], gap);
  endtask

  task automatic bd_write(input logic [15:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [31:0] nibs, input int n);
    send_hdr(8'h02, addr, 0);
    for (int k = 0; k < n; k++) sqi_beat(nibs[31-4*k -: 4], 0);
    cs_high();
  endtask

  // Expected nibbles are packed high-first in exp; first one must be visible after beat 10.
  task automatic do_read(input string tag, input logic [23:0] addr, input logic [31:0] exp,
                         input int n, input int gap);
    send_hdr(8'h03, addr, gap);
    sqi_beat(4'h0, gap);
    chk_val($sformatf("%s_oe_b9", tag), {31'd0, sio_oe}, 32'd0);
    sqi_beat(4'h0, gap);
    for (int k = 0; k < n; k++) begin
      chk_val($sformatf("%s_sio%0d", tag, k), {28'd0, sio_out}, {28'd0, exp[31-4*k -: 4]});
      chk_val($sformatf("%s_oe%0d", tag, k), {31'd0, sio_oe}, 32'd1);
      if (k < n - 1) sqi_beat(4'h0, gap);
    end
    cs_high();
    chk_val($sformatf("%s_oe_end", tag), {31'd0, sio_oe}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; sck = 1'b0; cs = 1'b1; sio_in = 4'h0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_oe", {31'd0, sio_oe}, 32'd0);
    chk_val("rst_sio", {28'd0, sio_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write then read back.
    do_write(24'h000010, 32'hA53C_0000, 4);
    do_read("rd10", 24'h000010, 32'hA53C_0000, 4, 0);

    // Backdoor preload and address wrap.
    bd_write(16'hFFFF, 8'h12);
    bd_write(16'h0000, 8'h34);
    do_read("wrap", 24'h00FFFF, 32'h1234_0000, 4, 0);

    // Partial byte discarded; neighbour untouched.
    bd_write(16'h0021, 8'h5E);
    do_write(24'h000020, 32'h7890_0000, 3);
    do_read("part", 24'h000020, 32'h785E_0000, 4, 0);

    // Unknown command: responder stays silent.
    sqi_beat(4'h9, 0);
    sqi_beat(4'hF, 0);
    for (int k = 0; k < 10; k++) begin
      sqi_beat(4'h3, 0);
      chk_val($sformatf("ign_oe%0d", k), {31'd0, sio_oe}, 32'd0);
    end
    cs_high();
    do_read("after_ign", 24'h000010, 32'hA500_0000, 2, 0);

    // Abort during address phase, then a full read.
    sqi_beat(4'h0, 0);
    sqi_beat(4'h3, 0);
    for (int k = 0; k < 3; k++) sqi_beat(4'hF, 0);
    cs_high();
    do_read("abort", 24'h000020, 32'h7800_0000, 2, 0);

    // Reset mid read data: outputs clear without a clock edge.
    send_hdr(8'h03, 24'h000010, 0);
    sqi_beat(4'h0, 0);
    sqi_beat(4'h0, 0);
    sqi_beat(4'h0, 0);
    chk_val("mid_oe", {31'd0, sio_oe}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("rstmid_oe", {31'd0, sio_oe}, 32'd0);
    chk_val("rstmid_sio", {28'd0, sio_out}, 32'd0);
    cs = 1'b1; sck = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read("retain", 24'h000010, 32'hA53C_0000, 4, 0);

    // sck gaps between every beat.
    do_read("gap", 24'h000010, 32'hA53C_0000, 4, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/idli_sqi_mem_m.md
# idli_sqi_mem_m

Synthesizable SQI serial-SRAM responder: the far end of the core's `mem_lo`/`mem_hi` SQI initiator interface. One instance per memory (low and high) sits in the bench beside the core, decodes READ/WRITE transactions driven on `sck`/`cs`/`sio`, and returns read data nibble-serially. A backdoor byte-write port lets the bench preload program images without driving the SQI protocol.

## Interface
- `ADDR_W`, default 16: implemented address bits; storage is 2**ADDR_W bytes; upper bits of the 24-bit SQI address are ignored.
- `i_sqi_gck`  in  1  clock, same clock as the core's `gck`.
- `i_sqi_rst_n`  in  1  reset, asynchronous, active-low.
- `i_sqi_sck`  in  1  SQI clock from core, sampled on `gck`, acts as beat enable.
- `i_sqi_cs`  in  1  chip select, active-low.
- `i_sqi_sio`  in  `slice_t` (4)  nibble from core.
- `o_sqi_sio`  out  `slice_t` (4)  nibble to core.
- `o_sqi_sio_oe`  out  1  responder driving `o_sqi_sio`.
- `i_sqi_bd_we`  in  1  backdoor byte write enable.
- `i_sqi_bd_addr`  in  `ADDR_W`  backdoor byte address.
- `i_sqi_bd_data`  in  8  backdoor byte data.

## Operation
- Beat: a rising `gck` edge with `i_sqi_cs`=0 and `i_sqi_sck`=1. All protocol state advances only on beats.
- Nibble order: high nibble first, for command, address, and data.
- States: IDLE, CMD (2 beats), ADDR (6 beats), DUMMY (2 beats, READ only), RD_DATA, WR_DATA, IGNORE.
- IDLE -> CMD on the first beat. That beat carries the command's high nibble.
- After CMD: 0x03 -> ADDR then DUMMY then RD_DATA. 0x02 -> ADDR then WR_DATA. Any other value -> IGNORE until `cs` rises; `oe` stays 0.
- 3-bit nibble counter; 24-bit address shift register, truncated to ADDR_W.
- RD_DATA:
  - The beat that ends DUMMY loads `o_sqi_sio` with the high nibble of `mem[addr]` and sets `oe`=1.
  - Each further beat alternates to the low nibble, then to the next byte's high nibble.
  - `addr` increments once per byte.
- WR_DATA:
  - The high-nibble beat latches into a holding register.
  - The low-nibble beat writes the full byte to `mem[addr]`, then `addr` increments.
- Address wraps from 2**ADDR_W-1 to 0.
- `cs`=1 on any edge: next state IDLE, `oe`=0, counter cleared. A partial byte (high nibble only) is discarded. Pending reads are abandoned.
- Backdoor: a `i_sqi_bd_we` edge writes `mem[bd_addr]` regardless of protocol state. If a protocol write hits the same address on the same edge, the backdoor data wins.
- Storage is not reset. Contents are X until written.

## Timing
- Reset values: state IDLE, `o_sqi_sio`=0, `o_sqi_sio_oe`=0, counter 0, address 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Read latency: first data nibble is valid after beat 10 (2 command + 6 address + 2 dummy). The core samples it on beat 11.
- Each subsequent nibble is valid one beat later. Gaps with `sck`=0 hold all state.
- A write commits on the edge of the byte's second data beat. A read of that byte in a later transaction returns the new value.
- Reset asserted mid-transaction: immediate return to reset values. Memory contents are kept.

## Structure
- `idli_pkg` gains:
  - `sqi_state_t` enum for the seven states.
  - `sqi_cmd_t` enum: `SQI_CMD_READ`=8'h03, `SQI_CMD_WRITE`=8'h02.
  - `SQI_ADDR_NIBBLES`=6 and `SQI_DUMMY_NIBBLES`=2.
- Existing `slice_t` is reused for the nibble ports.
- Sub-module `idli_sqi_ram_m`: byte array with one registered read port and one write port. The backdoor-priority mux sits in front of the write port.
- The FSM, counters and shift registers live in `idli_sqi_mem_m`.

## Test plan
- WRITE cmd 0x02, addr 0x000010, data 0xA5,0x3C; then READ 0x03, addr 0x000010, 2 dummy nibbles -> `o_sqi_sio` = A,5,3,C on beats 11-14, `oe`=1 from beat 11 until `cs` rises.
- Backdoor writes 0x12 to 0xFFFF and 0x34 to 0x0000; READ from 0xFFFF for 4 nibbles -> 1,2,3,4 (wrap).
- WRITE to 0x20 with 3 data nibbles 7,8,9, then `cs` high; READ 0x20 -> byte 0x78, byte 0x21 unchanged (partial byte discarded).
- Command 0x9F followed by 10 beats -> `oe` stays 0; next READ transaction behaves normally.
- `cs` raised after 3 address nibbles, then a full READ -> correct data; reset pulsed mid-RD_DATA -> `oe`=0 and `sio`=0 immediately, memory retained.
- `sck` held low for 3 `gck` between every beat of a READ -> identical nibble sequence, outputs held through gaps.
